// File: rtl/layer_scheduler.sv
// layer_scheduler
//   Time-shares one matrix_multiply engine and one relu engine across every
//   network layer (MM0,RELU0,MM1,RELU1,MM2,RELU2,MM3), then runs argmax.
//   It presents the per-layer dimensions and the layer index that selects
//   the weight ROM and the source/destination banks. A watchdog catches an
//   engine that never reports done.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start              inference request, sampled only while idle
//   abort              synchronous abort, honoured in any state
//   busy               high in every state except IDLE
//   done               one-cycle pulse when an inference completes
//   error              sticky watchdog flag, cleared by the next accepted start
//   layer_idx          current layer
//   mm_start/mm_done   matrix_multiply handshake; mm_n/mm_k give its shape
//   relu_start/relu_done  relu handshake; relu_d gives its length
//   argmax_start/argmax_done  argmax handshake
//
// State table
//   S_IDLE       | waiting for start
//   S_MM_START   | mm_start pulse for the current layer
//   S_MM_WAIT    | waiting for mm_done
//   S_RELU_START | relu_start pulse for the current layer
//   S_RELU_WAIT  | waiting for relu_done
//   S_AM_START   | argmax_start pulse
//   S_AM_WAIT    | waiting for argmax_done
//   S_DONE       | done pulse
//   S_ERROR      | watchdog expired; error is set
module layer_scheduler #(
  parameter int                          NUM_LAYERS = 4,
  parameter int                          DIM_W      = 10,
  parameter logic [NUM_LAYERS*DIM_W-1:0] LAYER_N    = {10'd10, 10'd32, 10'd64, 10'd64},
  parameter logic [NUM_LAYERS*DIM_W-1:0] LAYER_K    = {10'd32, 10'd64, 10'd64, 10'd784},
  parameter logic [19:0]                 TIMEOUT    = 20'd200000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       layer_idx,
  output logic             mm_start,
  output logic [DIM_W-1:0] mm_n,
  output logic [DIM_W-1:0] mm_k,
  input  logic             mm_done,
  output logic             relu_start,
  output logic [DIM_W-1:0] relu_d,
  input  logic             relu_done,
  output logic             argmax_start,
  input  logic             argmax_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MM_START,
    S_MM_WAIT,
    S_RELU_START,
    S_RELU_WAIT,
    S_AM_START,
    S_AM_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0]  LAST_IDX = 2'(NUM_LAYERS - 1);
  localparam logic [19:0] WDOG_LD  = TIMEOUT - 20'd1;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [1:0]       r_layer_idx;
  logic             r_mm_start;
  logic             r_relu_start;
  logic             r_am_start;
  logic [DIM_W-1:0] r_mm_n;
  logic [DIM_W-1:0] r_mm_k;
  logic [DIM_W-1:0] r_relu_d;
  logic [19:0]      r_wdog;

  logic [1:0]       w_layer_inc;
  logic [DIM_W-1:0] w_n_inc;
  logic [DIM_W-1:0] w_k_inc;
  logic [DIM_W-1:0] w_n_l0;
  logic [DIM_W-1:0] w_k_l0;
  logic             w_wdog_tc;

  assign w_layer_inc = r_layer_idx + 2'd1;
  assign w_n_inc     = LAYER_N[int'(w_layer_inc)*DIM_W +: DIM_W];
  assign w_k_inc     = LAYER_K[int'(w_layer_inc)*DIM_W +: DIM_W];
  assign w_n_l0      = LAYER_N[DIM_W-1:0];
  assign w_k_l0      = LAYER_K[DIM_W-1:0];
  // Watchdog is a down-counter loaded with TIMEOUT-1 on entering a WAIT
  // state, so terminal count is hit on the TIMEOUT-th waiting cycle.
  assign w_wdog_tc   = (r_wdog == 20'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_layer_idx  <= 2'd0;
      r_mm_start   <= 1'b0;
      r_relu_start <= 1'b0;
      r_am_start   <= 1'b0;
      r_mm_n       <= '0;
      r_mm_k       <= '0;
      r_relu_d     <= '0;
      r_wdog       <= 20'd0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      r_mm_start   <= 1'b0;
      r_relu_start <= 1'b0;
      r_am_start   <= 1'b0;
      r_done       <= 1'b0;
      if (abort) begin
        // Abort outranks any coincident start or engine done.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state     <= S_MM_START;
              r_busy      <= 1'b1;
              r_error     <= 1'b0;
              r_layer_idx <= 2'd0;
              r_mm_n      <= w_n_l0;
              r_mm_k      <= w_k_l0;
              r_relu_d    <= w_n_l0;
              r_mm_start  <= 1'b1;
            end
          end
          S_MM_START: begin
            r_state <= S_MM_WAIT;
            r_wdog  <= WDOG_LD;
          end
          S_MM_WAIT: begin
            if (mm_done) begin
              if (r_layer_idx == LAST_IDX) begin
                r_state    <= S_AM_START;
                r_am_start <= 1'b1;
              end else begin
                r_state      <= S_RELU_START;
                r_relu_start <= 1'b1;
              end
            end else if (w_wdog_tc) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_wdog <= r_wdog - 20'd1;
            end
          end
          S_RELU_START: begin
            r_state <= S_RELU_WAIT;
            r_wdog  <= WDOG_LD;
          end
          S_RELU_WAIT: begin
            if (relu_done) begin
              r_state     <= S_MM_START;
              r_layer_idx <= w_layer_inc;
              r_mm_n      <= w_n_inc;
              r_mm_k      <= w_k_inc;
              r_relu_d    <= w_n_inc;
              r_mm_start  <= 1'b1;
            end else if (w_wdog_tc) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_wdog <= r_wdog - 20'd1;
            end
          end
          S_AM_START: begin
            r_state <= S_AM_WAIT;
            r_wdog  <= WDOG_LD;
          end
          S_AM_WAIT: begin
            if (argmax_done) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_wdog_tc) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_wdog <= r_wdog - 20'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          S_ERROR: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign layer_idx    = r_layer_idx;
  assign mm_start     = r_mm_start;
  assign mm_n         = r_mm_n;
  assign mm_k         = r_mm_k;
  assign relu_start   = r_relu_start;
  assign relu_d       = r_relu_d;
  assign argmax_start = r_am_start;

endmodule
